rle_multi_buffer_fifo: RTL
==========================

RLE_MULTI_BUFFER_FIFO -- requirements
Module: rle_multi_buffer_fifo

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset; the ports SHALL be named clk and reset.
REQ-002 The block SHALL have these parameters:
- WIDTH, default 20, width of each RLE word.
- DEPTH, default 64, number of words per buffer; must be at least 2.
- NBUF, default 2, number of buffers; legal range 2..4.
REQ-003 The block SHALL have these ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- data_in  in  WIDTH  RLE word to write.
- wren  in  1  write strobe.
- buf_done  in  1  single-cycle strobe that commits the current write buffer.
- rd_req  in  1  read request.
- data_out  out  WIDTH  registered read data.
- data_valid  out  1  data_out is valid this cycle.
- fifo_empty  out  1  no committed buffer is available to read.
- wr_full  out  1  a write would be refused.
- overflow  out  1  sticky flag: a write was refused.
- committed  out  clog2(NBUF+1)  number of committed, unread buffers.

Function
REQ-004 Buffer order: buffers SHALL be used in ring order 0..NBUF-1. The block SHALL track:
- write buffer index wb and write count wcnt (0..DEPTH);
- read buffer index rb and read count rcnt;
- a stored length len[b] for each buffer.
REQ-005 Accepted write: wren=1 and wr_full=0 SHALL store data_in at buffer wb, address wcnt, then increment wcnt.
REQ-006 wr_full SHALL be combinational and equal 1 when wcnt==DEPTH or committed==NBUF.
REQ-007 Refused write: wren=1 while wr_full=1 SHALL discard data_in and set overflow to 1.
- overflow SHALL stay 1 until reset.
REQ-008 Commit: buf_done=1 with committed<NBUF and an effective count >0 SHALL:
- set len[wb] to the effective count;
- advance wb modulo NBUF;
- clear wcnt to 0;
- increment committed.
The effective count is wcnt+1 when a write is accepted in the same cycle, otherwise wcnt.
REQ-009 A buf_done with effective count 0 SHALL be ignored with no state change.
REQ-010 wren and buf_done in the same cycle: the written word SHALL belong to the buffer being committed.
REQ-011 fifo_empty SHALL be combinational and equal (committed==0).
REQ-012 Accepted read: rd_req=1 with fifo_empty=0 SHALL register word rb[rcnt] into data_out and assert data_valid on the next cycle (read latency 1).
REQ-013 Ignored read: rd_req with fifo_empty=1 SHALL be ignored.
- data_valid SHALL be 0 on the next cycle.
- data_out SHALL hold its previous value.
REQ-014 Reads within a buffer: an accepted read with rcnt<len[rb]-1 SHALL increment rcnt.
REQ-015 Last read of a buffer: an accepted read with rcnt==len[rb]-1 SHALL:
- clear rcnt to 0;
- advance rb modulo NBUF;
- decrement committed.
REQ-016 A commit and a last-word read in the same cycle SHALL leave committed unchanged; both pointer updates SHALL take effect.
REQ-017 A buffer that has just been freed by a last-word read SHALL accept writes from the next cycle onward.
REQ-018 committed SHALL never exceed NBUF or go below 0.
REQ-019 Committed data SHALL never be overwritten before it has been read.
REQ-020 Data SHALL leave the block in exact write order, across all buffers.
REQ-021 wcnt, rcnt and len SHALL be sized clog2(DEPTH+1) bits.
REQ-022 Index wrap SHALL use an explicit compare against NBUF-1, so that non-power-of-2 NBUF works.

Reset
REQ-023 While reset=0, the block SHALL asynchronously force:
- data_out=0, data_valid=0, overflow=0, committed=0;
- fifo_empty=1, wr_full=0;
- wb, rb, wcnt and rcnt to 0.
REQ-024 Reset asserted mid-operation SHALL discard all buffered data. Memory contents need not be cleared.
REQ-025 The first accepted write SHALL be possible on the first rising clk edge after reset returns to 1.

Verification
REQ-026 Basic ping-pong, NBUF=2, DEPTH=64:
- write 5 words 0x00001..0x00005, pulse buf_done -> committed=1, fifo_empty=0;
- 5 rd_req -> data_out 0x00001..0x00005, each one cycle after its request -> committed=0, fifo_empty=1.
REQ-027 Full and overflow:
- commit 2 buffers, then wren with data_in=0xABCDE -> wr_full=1, overflow=1, word never appears on data_out;
- read one buffer completely -> wr_full=0 on the next cycle.
REQ-028 Same-cycle write and commit: write 3 words, then wren and buf_done together with data_in=0x0000F -> len=4, and the reads return 4 words ending with 0x0000F.
REQ-029 Same-cycle commit and last read, NBUF=3: buf_done on the cycle of the final rd_req of the read buffer -> committed unchanged, and the next read returns the first word of the next buffer.
REQ-030 Reset and empty read:
- rd_req while empty -> data_valid stays 0;
- reset pulled low mid-read with 2 buffers committed -> committed=0, fifo_empty=1, overflow=0 immediately, without waiting for a clk edge.
REQ-031 Buffer depth limit, DEPTH=4: 5 wren pulses -> only 4 words stored, wr_full=1 after the 4th, overflow=1.

Source files
------------

// File: rtl/rle_multi_buffer_fifo.sv
`default_nettype none
// ============================================================================
// Module   : rle_multi_buffer_fifo
// Purpose  : Ring of NBUF buffers. Whole RLE word buffers are committed as units and read back in order.
// Revision : 1.0
// ============================================================================
module rle_multi_buffer_fifo #(
  parameter int WIDTH = 20,
  parameter int DEPTH = 64,
  parameter int NBUF  = 2
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [WIDTH-1:0]             data_in,
  input  logic                         wren,
  input  logic                         buf_done,
  input  logic                         rd_req,
  output logic [WIDTH-1:0]             data_out,
  output logic                         data_valid,
  output logic                         fifo_empty,
  output logic                         wr_full,
  output logic                         overflow,
  output logic [$clog2(NBUF+1)-1:0]    committed
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int AW = $clog2(DEPTH);
  localparam int BW = $clog2(NBUF);
  localparam int KW = $clog2(NBUF + 1);

  logic [WIDTH-1:0] mem [NBUF][DEPTH];
  logic [CW-1:0]    len [NBUF];
  logic [BW-1:0]    wb, rb;
  logic [CW-1:0]    wcnt, rcnt;

  logic             wr_acc, rd_acc, rd_last, commit;
  logic [CW-1:0]    eff_cnt;
  logic [BW-1:0]    wb_next, rb_next;

  assign wr_full    = (wcnt == CW'(DEPTH)) || (committed == KW'(NBUF));
  assign fifo_empty = (committed == '0);
  assign wr_acc     = wren && !wr_full;
  assign rd_acc     = rd_req && !fifo_empty;
  // A word accepted alongside buf_done belongs to the buffer being committed.
  assign eff_cnt    = wcnt + CW'(wr_acc);
  assign commit     = buf_done && (committed < KW'(NBUF)) && (eff_cnt != '0);
  assign rd_last    = rd_acc && (rcnt == len[rb] - CW'(1));
  assign wb_next    = (wb == BW'(NBUF - 1)) ? '0 : wb + BW'(1);
  assign rb_next    = (rb == BW'(NBUF - 1)) ? '0 : rb + BW'(1);

  always_ff @(posedge clk) begin
    if (wr_acc) mem[wb][wcnt[AW-1:0]] <= data_in;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      data_out   <= '0;
      data_valid <= 1'b0;
      overflow   <= 1'b0;
      committed  <= '0;
      wb         <= '0;
      rb         <= '0;
      wcnt       <= '0;
      rcnt       <= '0;
      for (int i = 0; i < NBUF; i++) len[i] <= '0;
    end else begin
      data_valid <= rd_acc;
      if (rd_acc) data_out <= mem[rb][rcnt[AW-1:0]];
      if (wren && wr_full) overflow <= 1'b1;

      if (commit) begin
        len[wb] <= eff_cnt;
        wb      <= wb_next;
        wcnt    <= '0;
      end else if (wr_acc) begin
        wcnt <= wcnt + CW'(1);
      end

      if (rd_last) begin
        rcnt <= '0;
        rb   <= rb_next;
      end else if (rd_acc) begin
        rcnt <= rcnt + CW'(1);
      end

      if (commit && !rd_last)      committed <= committed + KW'(1);
      else if (!commit && rd_last) committed <= committed - KW'(1);
    end
  end

endmodule
`default_nettype wire
